fpu_mul_fsm: RTL and testbench



---
 rtl/fpu_mul_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_fpu_mul_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_fsm.sv
// Multi-cycle FP32 multiplier (FTZ) with an iterative shift-add mantissa datapath.
// Define FMUL_RNE_EN for round-to-nearest-even; default build truncates.
module fpu_mul_fsm #(
  parameter int unsigned ITER_BITS = 1  // 1, 2 or 4 multiplier bits per MULT cycle
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ITERS = 24 / ITER_BITS;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXP_W = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_PACK   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [31:0]             a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic [23:0]             ma_q, ma_d, mb_q, mb_d;
  logic [47:0]             p_q, p_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [22:0]             frac_q, frac_d;
  logic                    g_q, g_d, s_q, s_d;
  logic                    spec_q, spec_d;
  logic [31:0]             spec_val_q, spec_val_d;
  logic [31:0]             result_q, result_d;
  logic                    busy_q, busy_d, done_q, done_d;

  // Operand classification of the latched operands
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        spec_c;
  logic [31:0] spec_val_c;

  always_comb begin
    a_zero     = (a_q[30:23] == 8'h00);
    b_zero     = (b_q[30:23] == 8'h00);
    a_inf      = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf      = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    spec_c     = 1'b1;
    spec_val_c = 32'd0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_val_c = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      spec_val_c = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      spec_val_c = {a_q[31] ^ b_q[31], 31'd0};
    end else begin
      spec_c = 1'b0;
    end
  end

  // Partial product for the current group of multiplier bits, placed at its bit position
  logic [47:0] pp;
  logic [5:0]  shamt;

  always_comb begin
    pp = 48'd0;
    for (int j = 0; j < int'(ITER_BITS); j++) begin
      if (mb_q[j]) pp = pp + (48'(ma_q) << j);
    end
  end

  assign shamt = 6'(cnt_q) * 6'(ITER_BITS);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = spec_c ? S_PACK : S_MULT;
      S_MULT:   if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_PACK;
      S_PACK:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
`ifdef FMUL_RNE_EN
  logic [23:0] frac_inc;
  assign frac_inc = {1'b0, frac_q} + 24'd1;
`endif

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    frac_d     = frac_q;
    g_d        = g_q;
    s_d        = s_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          busy_d = 1'b1;
        end
      end
      S_UNPACK: begin
        sign_d     = a_q[31] ^ b_q[31];
        ma_d       = {1'b1, a_q[22:0]};
        mb_d       = {1'b1, b_q[22:0]};
        p_d        = 48'd0;
        cnt_d      = '0;
        spec_d     = spec_c;
        spec_val_d = spec_val_c;
      end
      S_MULT: begin
        p_d   = p_q + (pp << shamt);
        mb_d  = mb_q >> ITER_BITS;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          exp_d = $signed(EXP_W'(a_q[30:23]) + EXP_W'(b_q[30:23]) - EXP_W'(127));
        end
      end
      S_NORM: begin
        if (p_q[47]) begin
          frac_d = p_q[46:24];
          g_d    = p_q[23];
          s_d    = |p_q[22:0];
          exp_d  = exp_q + 10'sd1;
        end else begin
          frac_d = p_q[45:23];
          g_d    = p_q[22];
          s_d    = |p_q[21:0];
        end
      end
      S_ROUND: begin
`ifdef FMUL_RNE_EN
        if (g_q && (s_q || frac_q[0])) begin
          frac_d = frac_inc[22:0];
          if (frac_inc[23]) exp_d = exp_q + 10'sd1;
        end
`endif
      end
      S_PACK: begin
        if (spec_q)                  result_d = spec_val_q;
        else if (exp_q >= 10'sd255)  result_d = {sign_q, 8'hFF, 23'd0};
        else if (exp_q <= 10'sd0)    result_d = {sign_q, 31'd0};
        else                         result_d = {sign_q, exp_q[7:0], frac_q};
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sign_q     <= 1'b0;
      ma_q       <= 24'd0;
      mb_q       <= 24'd0;
      p_q        <= 48'd0;
      cnt_q      <= '0;
      exp_q      <= '0;
      frac_q     <= 23'd0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      result_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      frac_q     <= frac_d;
      g_q        <= g_d;
      s_q        <= s_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fpu_mul_fsm.sv
// Bench for fpu_mul_fsm: three instances (ITER_BITS 1/2/4) checked against an arithmetic FP32 model.
module tb_fpu_mul_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [31:0] a, b;
  logic [31:0] res [3];
  logic [2:0]  busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  fpu_mul_fsm #(.ITER_BITS(1)) u_dut1 (.clk(clk), .rst(rst), .start(start[0]), .A(a), .B(b),
                                       .result(res[0]), .busy(busy[0]), .done(done[0]));
  fpu_mul_fsm #(.ITER_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .start(start[1]), .A(a), .B(b),
                                       .result(res[1]), .busy(busy[1]), .done(done[1]));
  fpu_mul_fsm #(.ITER_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .start(start[2]), .A(a), .B(b),
                                       .result(res[2]), .busy(busy[2]), .done(done[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (done[i]) ndone[i]++;
  end

  function automatic int iters(input int idx);
    return (idx == 0) ? 24 : (idx == 1) ? 12 : 6;
  endfunction

  // FP32 product from field arithmetic: FTZ, truncate or RNE, saturate to Inf, flush underflow
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          output bit special);
    int ex, ey, e, shift;
    longint unsigned mx, my, p, rem, half, frac;
    bit sgn, xn, yn, xi, yi, xz, yz;
    sgn = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    special = 1'b1;
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi) return {sgn, 8'hFF, 23'd0};
    if (xz || yz) return {sgn, 31'd0};
    special = 1'b0;
    mx = 64'h80_0000 + longint'(x[22:0]);
    my = 64'h80_0000 + longint'(y[22:0]);
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      shift = 24;
      e++;
    end else begin
      shift = 23;
    end
    frac = p >> shift;
    rem  = p & ((64'd1 << shift) - 64'd1);
    half = 64'd1 << (shift - 1);
`ifdef FMUL_RNE_EN
    if (rem > half || (rem == half && frac[0])) frac++;
    if (frac >= (64'd1 << 24)) begin
      frac = frac >> 1;
      e++;
    end
`else
    if (rem > half) frac = frac + 64'd0;
`endif
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0) return {sgn, 31'd0};
    return {sgn, 8'(e), 23'(frac)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: v[30:23] = 8'h00;
      3, 4: ;
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, result, busy profile and result hold
  task automatic run_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int lat, input bit b2b, input string tag);
    logic [31:0] prev;
    bit busy_ok, hold_ok, got;
    int n;
    prev = res[idx];
    if (!b2b) @(negedge clk);
    a = x;
    b = y;
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    busy_ok = busy[idx];
    hold_ok = 1'b1;
    got = 1'b0;
    n = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (done[idx]) got = 1'b1;
      else begin
        if (!busy[idx]) busy_ok = 1'b0;
        if (res[idx] !== prev) hold_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, res[idx], exp_r);
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_result_held"}, 32'(hold_ok), 32'd1);
    chk({tag, "_busy_low_at_done"}, 32'(busy[idx]), 32'd0);
  endtask

  task automatic run_rand(input int idx);
    logic [31:0] x, y, e;
    bit sp;
    x = rand_op();
    y = rand_op();
    e = ref_mul(x, y, sp);
    run_op(idx, x, y, e, sp ? 2 : 4 + iters(idx), 1'b0, $sformatf("rand%0d_%h_%h", idx, x, y));
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    start = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_result%0d", i), res[i], 32'd0);
      chk($sformatf("reset_busy_done%0d", i), 32'({busy[i], done[i]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 28, 1'b0, "two_x_three_i1");
    run_op(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 16, 1'b0, "two_x_three_i2");
    run_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 10, 1'b0, "two_x_three_i4");
    run_op(0, 32'hBFC0_0000, 32'h3FC0_0000, 32'hC010_0000, 28, 1'b0, "neg_product");
    run_op(0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 28, 1'b0, "overflow_inf");
    run_op(0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 2, 1'b0, "zero_x_inf");
    run_op(0, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 2, 1'b0, "negzero_x_two");
    run_op(0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 28, 1'b0, "underflow");
`ifdef FMUL_RNE_EN
    run_op(0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 28, 1'b0, "round_case");
    run_op(2, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 10, 1'b0, "round_case_i4");
`else
    run_op(0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 28, 1'b0, "round_case");
    run_op(2, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 10, 1'b0, "round_case_i4");
`endif
    // start accepted in the done cycle
    run_op(1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 16, 1'b0, "b2b_first");
    run_op(1, 32'hC040_0000, 32'h4080_0000, 32'hC140_0000, 16, 1'b1, "b2b_second");

    // start pulses while busy are ignored
    base = ndone[0];
    @(negedge clk);
    a = 32'h3FC0_0000;
    b = 32'h4000_0000;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (4) @(negedge clk);
      a = 32'h4040_0000;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
    end
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 32'(ndone[0] - base), 32'd1);
    chk("ignored_start_result", res[0], 32'h4040_0000);

    // reset in the middle of MULT aborts without done
    @(negedge clk);
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_result", res[0], 32'd0);
    chk("abort_busy_done", 32'({busy[0], done[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = ndone[0];
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(ndone[0] - base), 32'd0);
    chk("abort_idle_busy", 32'(busy[0]), 32'd0);

    for (int i = 0; i < 60; i++) run_rand(i % 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
